food_spawn_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 16 +
 rtl/food_spawn_ctrl.sv | 128 ++++++++++++
 tb/tb_food_spawn_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared board geometry, FSM state encoding and segment extraction helper
// for the two-player snake game.
package snake_pkg;

    localparam int MAX_LEN = 15;
    localparam int NUM_LEN = 10;
    localparam int WIDTH   = 32;
    localparam int HEIGHT  = 24;
    localparam int CELLS   = WIDTH * HEIGHT;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SCAN,
        CHECK
    } state_t;

    function automatic logic [NUM_LEN-1:0] seg_at(
        input logic [MAX_LEN*NUM_LEN-1:0] bus,
        input logic [LEN_W-1:0]           idx
    );
        return bus[idx*NUM_LEN +: NUM_LEN];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last-served pointer lives in the parent.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gid,
    input  logic       en,
    output logic       gid,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = en & (|req);
        // On contention the player not served last wins.
        gid       = (&req) ? ~last_gid : req[1];
    end

endmodule

// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: arbitrates eaten-food requests, draws candidates
// from the LFSR, scans both snakes and publishes a collision-free position.
module food_spawn_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_TRIES  = 8,
    parameter int INIT_FOOD1 = 100,
    parameter int INIT_FOOD2 = 600
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req,
    input  logic [NUM_LEN-1:0]         rand_in,
    input  logic [MAX_LEN*NUM_LEN-1:0] snake1,
    input  logic [MAX_LEN*NUM_LEN-1:0] snake2,
    input  logic [LEN_W-1:0]           len1,
    input  logic [LEN_W-1:0]           len2,
    output logic [NUM_LEN-1:0]         food1,
    output logic [NUM_LEN-1:0]         food2,
    output logic [1:0]                 done,
    output logic                       busy
);

    localparam int                 TRY_W     = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]   TRY_SAT   = TRY_W'(MAX_TRIES);
    localparam logic [NUM_LEN:0]   CELLS_X   = (NUM_LEN+1)'(CELLS);
    localparam logic [LEN_W-1:0]   SEG_LAST  = LEN_W'(MAX_LEN - 1);
    localparam logic [NUM_LEN-1:0] FOOD1_RST = NUM_LEN'(INIT_FOOD1);
    localparam logic [NUM_LEN-1:0] FOOD2_RST = NUM_LEN'(INIT_FOOD2);

    state_t             state;
    logic               gid_reg;
    logic               last_gid;
    logic [NUM_LEN-1:0] cand;
    logic [LEN_W-1:0]   seg;
    logic               hit;
    logic [TRY_W-1:0]   tries;

    logic               arb_gid;
    logic               arb_valid;
    logic [NUM_LEN:0]   cand_inc;
    logic [NUM_LEN-1:0] cand_wrap;
    logic               seg_hit;
    logic               bad;

    rr_arbiter2 u_arb (
        .req       (req),
        .last_gid  (last_gid),
        .en        (state == IDLE),
        .gid       (arb_gid),
        .gnt_valid (arb_valid)
    );

    // Linear probe wraps at the last board cell, and also at index overflow
    // so a probe starting off-board still returns to cell 0.
    assign cand_inc  = {1'b0, cand} + (NUM_LEN+1)'(1);
    assign cand_wrap = ((cand_inc == CELLS_X) || cand_inc[NUM_LEN]) ? '0
                                                                     : cand_inc[NUM_LEN-1:0];

    assign seg_hit = ((seg < len1) && (cand == seg_at(snake1, seg))) ||
                     ((seg < len2) && (cand == seg_at(snake2, seg)));

    assign bad = hit || ({1'b0, cand} >= CELLS_X) || (cand == food1) || (cand == food2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gid_reg  <= 1'b0;
            last_gid <= 1'b0;
            cand     <= '0;
            seg      <= '0;
            hit      <= 1'b0;
            tries    <= '0;
            food1    <= FOOD1_RST;
            food2    <= FOOD2_RST;
            done     <= 2'b00;
            busy     <= 1'b0;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gid_reg <= arb_gid;
                        busy    <= 1'b1;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    cand  <= (tries < TRY_SAT) ? rand_in : cand_wrap;
                    seg   <= '0;
                    hit   <= 1'b0;
                    state <= SCAN;
                end
                SCAN: begin
                    hit <= hit | seg_hit;
                    seg <= seg + LEN_W'(1);
                    if (seg == SEG_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad) begin
                        if (tries < TRY_SAT) begin
                            tries <= tries + TRY_W'(1);
                        end
                        state <= DRAW;
                    end else begin
                        if (gid_reg) begin
                            food2 <= cand;
                        end else begin
                            food1 <= cand;
                        end
                        done     <= gid_reg ? 2'b10 : 2'b01;
                        tries    <= '0;
                        last_gid <= gid_reg;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed and randomized bench for food_spawn_ctrl against a placement model
// that searches for the first legal cell from the draw sequence.
module tb_food_spawn_ctrl;
    import snake_pkg::*;

    localparam int MAX_TRIES = 8;
    localparam int ATTEMPT   = MAX_LEN + 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [1:0]                 req = 2'b00;
    logic [NUM_LEN-1:0]         rand_in = '0;
    logic [MAX_LEN*NUM_LEN-1:0] snake1 = '0;
    logic [MAX_LEN*NUM_LEN-1:0] snake2 = '0;
    logic [LEN_W-1:0]           len1 = 4'd1;
    logic [LEN_W-1:0]           len2 = 4'd1;
    logic [NUM_LEN-1:0]         food1;
    logic [NUM_LEN-1:0]         food2;
    logic [1:0]                 done;
    logic                       busy;

    int s1[MAX_LEN];
    int s2[MAX_LEN];
    int l1, l2;
    int seq[MAX_TRIES];
    int efood[2];
    int last_served;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    food_spawn_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rand_in (rand_in),
        .snake1  (snake1),
        .snake2  (snake2),
        .len1    (len1),
        .len2    (len2),
        .food1   (food1),
        .food2   (food2),
        .done    (done),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_snakes();
        for (int i = 0; i < MAX_LEN; i++) begin
            snake1[i*NUM_LEN +: NUM_LEN] = NUM_LEN'(s1[i]);
            snake2[i*NUM_LEN +: NUM_LEN] = NUM_LEN'(s2[i]);
        end
        len1 = LEN_W'(l1);
        len2 = LEN_W'(l2);
    endtask

    function automatic bit is_bad(input int c);
        if (c >= CELLS || c == efood[0] || c == efood[1]) return 1'b1;
        for (int i = 0; i < l1; i++) if (s1[i] == c) return 1'b1;
        for (int i = 0; i < l2; i++) if (s2[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // First MAX_TRIES draws come from the random sequence, then a wrapping
    // linear probe continues from the last candidate.
    task automatic model(output int draws, output int pos);
        int c;
        c = 0;
        draws = 0;
        pos = 0;
        for (int d = 0; d < 4096; d++) begin
            if (d < MAX_TRIES) c = seq[d];
            else begin
                c = c + 1;
                if (c == CELLS || c == (1 << NUM_LEN)) c = 0;
            end
            if (!is_bad(c)) begin
                draws = d + 1;
                pos = c;
                return;
            end
        end
    endtask

    function automatic int pick_rand();
        int m;
        m = int'($urandom_range(9, 0));
        if (m < 2) return s1[$urandom_range(MAX_LEN-1, 0)];
        if (m < 4) return s2[$urandom_range(MAX_LEN-1, 0)];
        if (m < 6) return int'($urandom_range((1 << NUM_LEN) - 1, CELLS));
        if (m == 6) return efood[$urandom_range(1, 0)];
        return int'($urandom_range(CELLS-1, 0));
    endfunction

    task automatic random_world();
        for (int i = 0; i < MAX_LEN; i++) begin
            s1[i] = int'($urandom_range(CELLS-1, 0));
            s2[i] = int'($urandom_range(CELLS-1, 0));
        end
        l1 = int'($urandom_range(MAX_LEN, 1));
        l2 = int'($urandom_range(MAX_LEN, 1));
        apply_snakes();
    endtask

    task automatic random_seq();
        for (int i = 0; i < MAX_TRIES; i++) seq[i] = pick_rand();
    endtask

    // Called at a negedge; drives req and walks rand_in through seq so that
    // draw d sees seq[d]. Returns at the negedge where done is observed.
    task automatic serve(input logic [1:0] r);
        int who, k, pos, cyc, d;
        bit got;
        who = (r == 2'b11) ? 1 - last_served : (r[1] ? 1 : 0);
        model(k, pos);
        req = r;
        rand_in = NUM_LEN'(seq[0]);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < ATTEMPT * k + 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done !== 2'b00) begin
                got = 1'b1;
                chk("done_cycle", cyc, 1 + ATTEMPT * k);
                chk("done_who", {30'd0, done}, who ? 2 : 1);
                efood[who] = pos;
                last_served = who;
                chk("food1", {22'd0, food1}, efood[0]);
                chk("food2", {22'd0, food2}, efood[1]);
                $display("place who=%0d draws=%0d pos=%0d food1=%0d food2=%0d",
                         who + 1, k, pos, food1, food2);
                req = r & ~(who ? 2'b10 : 2'b01);
            end else begin
                chk("busy_during", {31'd0, busy}, 1);
                if (cyc >= 2 && (cyc - 2) % ATTEMPT == 0) begin
                    d = (cyc - 2) / ATTEMPT + 1;
                    if (d < MAX_TRIES) rand_in = NUM_LEN'(seq[d]);
                end
            end
        end
        chk("done_seen", {31'd0, got}, 1);
    endtask

    initial begin
        int f_a, f_b;
        logic [1:0] r;
        efood[0] = 100;
        efood[1] = 600;
        last_served = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            s1[i] = 10 + i;
            s2[i] = 400 + i;
        end
        l1 = 5;
        l2 = 5;
        apply_snakes();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_food1", {22'd0, food1}, 100);
        chk("rst_food2", {22'd0, food2}, 600);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {30'd0, done}, 0);

        // First-draw success at 300.
        for (int i = 0; i < MAX_TRIES; i++) seq[i] = 300;
        serve(2'b01);
        chk("food1_300", {22'd0, food1}, 300);
        chk("food2_kept", {22'd0, food2}, 600);
        @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 0);

        // One rejection on snake2[3], then success at 200.
        s2[3] = 5;
        l2 = 4;
        apply_snakes();
        seq[0] = 5;
        for (int i = 1; i < MAX_TRIES; i++) seq[i] = 200;
        serve(2'b01);
        chk("food1_200", {22'd0, food1}, 200);

        // Simultaneous requests: player 2 first because player 1 was last.
        random_seq();
        serve(2'b11);
        chk("rr_first_p2", {31'd0, last_served[0]}, 1);
        random_seq();
        serve(2'b01);
        chk("foods_differ", {31'd0, food1 != food2}, 1);

        // Off-board stuck LFSR forces fallback probe that wraps to 0.
        for (int i = 0; i < MAX_TRIES; i++) seq[i] = 900;
        serve(2'b01);
        chk("fallback_zero", {22'd0, food1}, 0);

        // Randomized placements.
        for (int it = 0; it < 25; it++) begin
            random_world();
            r = 2'($urandom_range(3, 1));
            random_seq();
            serve(r);
            if (r == 2'b11) begin
                f_a = efood[0];
                f_b = efood[1];
                random_seq();
                serve(last_served == 1 ? 2'b01 : 2'b10);
                chk("pair_distinct", {31'd0, efood[0] != efood[1]}, 1);
                chk("pair_changed", {31'd0, (efood[0] != f_a) || (efood[1] != f_b)}, 1);
            end
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a scan.
        random_world();
        random_seq();
        req = 2'b01;
        rand_in = NUM_LEN'(seq[0]);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("busy_pre_rst", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_food1", {22'd0, food1}, 100);
        chk("mid_rst_food2", {22'd0, food2}, 600);
        chk("mid_rst_done", {30'd0, done}, 0);
        req = 2'b00;
        efood[0] = 100;
        efood[1] = 600;
        last_served = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", {30'd0, done}, 0);
        end
        random_seq();
        serve(2'b10);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
